// File: rtl/mm_pkg.sv
// Shared constants, FSM encoding and index-width helper for the matrix-multiplier result path.
package mm_pkg;

  localparam int MM_DATA_WIDTH = 8;
  localparam int MM_M          = 8;
  localparam int MM_P          = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_CHKSUM = 2'd2
  } mm_state_e;

  // Index width for n entries; a single-entry dimension still gets one bit.
  function automatic int idx_width(input int n);
    if (n > 1) return $clog2(n);
    return 1;
  endfunction

endpackage

// File: rtl/mm_result_streamer_if.sv
// Result beat stream: one matrix element per beat with its row/column position.
interface mm_result_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 8,
  parameter int P          = 8
);

  localparam int ROW_W = mm_pkg::idx_width(M);
  localparam int COL_W = mm_pkg::idx_width(P);

  // A beat transfers on a rising clk edge where m_valid & m_ready. Once m_valid
  // is high, m_data/m_row/m_col/m_last hold and m_valid stays high until that
  // transfer; m_ready may toggle freely and never depends on m_valid.
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [ROW_W-1:0]      m_row;
  logic [COL_W-1:0]      m_col;
  logic                  m_last;

  modport master (
    output m_valid, m_data, m_row, m_col, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_row, m_col, m_last,
    output m_ready
  );

endinterface

// File: rtl/mm_rc_index_counter.sv
// Row-major row/column walker with enable, synchronous clear and a flag on the final position.
module mm_rc_index_counter
  import mm_pkg::*;
#(
  parameter int ROWS = MM_M,
  parameter int COLS = MM_P
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  output logic [idx_width(ROWS)-1:0] row,
  output logic [idx_width(COLS)-1:0] col,
  output logic                       last
);

  localparam int ROW_W = idx_width(ROWS);
  localparam int COL_W = idx_width(COLS);

  logic row_end;
  logic col_end;

  assign row_end = (row == ROW_W'(ROWS - 1));
  assign col_end = (col == COL_W'(COLS - 1));
  assign last    = row_end & col_end;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mm_result_streamer.sv
// Snapshots the multiplier result on a done rise and streams it row-major, one element per beat.
// Optional trailing checksum beat: define MM_RESULT_STREAMER_CHECKSUM_EN.
module mm_result_streamer
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = MM_DATA_WIDTH,
  parameter int M          = MM_M,
  parameter int P          = MM_P
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         done_in,
  input  logic [M*P*DATA_WIDTH-1:0]    result_c,
  mm_result_streamer_if.master         m,
  output logic                         busy,
  output logic                         overrun,
  output mm_state_e                    state
);

  localparam int ROW_W = idx_width(M);
  localparam int COL_W = idx_width(P);

  mm_state_e             state_next;
  logic                  done_q;
  logic                  done_rise;
  logic                  valid;
  logic                  hs;
  logic                  capture;
  logic                  drop;
  logic                  cnt_en;
  logic                  cnt_clr;
  logic                  cnt_last;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic [DATA_WIDTH-1:0] snap [M][P];
  logic [DATA_WIDTH-1:0] elem;

  assign done_rise = done_in & ~done_q;
  assign valid     = (state != ST_IDLE);
  assign hs        = valid & m.m_ready;
  assign elem      = snap[row][col];

  mm_rc_index_counter #(
    .ROWS (M),
    .COLS (P)
  ) u_index (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .row  (row),
    .col  (col),
    .last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_in;
    end
  end

  // A rise coinciding with the frame's final handshake is the only one accepted mid-frame.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    drop       = 1'b0;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (done_rise) begin
          capture    = 1'b1;
          cnt_clr    = 1'b1;
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (hs && cnt_last) begin
`ifdef MM_RESULT_STREAMER_CHECKSUM_EN
          state_next = ST_CHKSUM;
          drop       = done_rise;
`else
          cnt_clr = 1'b1;
          if (done_rise) capture = 1'b1;
          else           state_next = ST_IDLE;
`endif
        end else begin
          cnt_en = hs;
          drop   = done_rise;
        end
      end
`ifdef MM_RESULT_STREAMER_CHECKSUM_EN
      ST_CHKSUM: begin
        if (hs) begin
          cnt_clr = 1'b1;
          if (done_rise) begin
            capture    = 1'b1;
            state_next = ST_STREAM;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          drop = done_rise;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < P; j++) begin
          snap[i][j] <= result_c[(i*P+j)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       overrun <= 1'b0;
    else if (drop) overrun <= 1'b1;
  end

`ifdef MM_RESULT_STREAMER_CHECKSUM_EN
  // Running sum of the elements already sent; complete when the checksum beat presents.
  logic [DATA_WIDTH-1:0] csum;

  always_ff @(posedge clk) begin
    if (rst || capture)                csum <= '0;
    else if (state == ST_STREAM && hs) csum <= csum + elem;
  end

  assign m.m_data = (state == ST_CHKSUM) ? csum : (valid ? elem : '0);
  assign m.m_last = (state == ST_CHKSUM);
`else
  assign m.m_data = valid ? elem : '0;
  assign m.m_last = (state == ST_STREAM) & cnt_last;
`endif

  assign m.m_valid = valid;
  assign m.m_row   = row;
  assign m.m_col   = col;
  assign busy      = valid;

endmodule

// File: tb/tb_mm_result_streamer.sv
// Self-checking bench for mm_result_streamer: frame table, corner-case sequences, beat scoreboard.
module tb_mm_result_streamer;
  import mm_pkg::*;

  localparam int DW = 8;
  localparam int M  = 8;
  localparam int P  = 8;
  localparam int N  = M * P;
  localparam int RW = 3;
  localparam int CW = 3;
  localparam int BW = 1 + RW + CW + DW;
`ifdef MM_RESULT_STREAMER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int FRAME_LEN = N + (CHK ? 1 : 0);

  logic            clk = 1'b0;
  logic            rst;
  logic            done_in;
  logic [N*DW-1:0] result_c;
  logic            busy;
  logic            overrun;
  mm_state_e       state;

  mm_result_streamer_if #(.DATA_WIDTH(DW), .M(M), .P(P)) bus ();

  mm_result_streamer #(.DATA_WIDTH(DW), .M(M), .P(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .done_in  (done_in),
    .result_c (result_c),
    .m        (bus),
    .busy     (busy),
    .overrun  (overrun),
    .state    (state)
  );

  always #5 clk = ~clk;

  int             tests = 0;
  int             fails = 0;
  int             frame_beats = 0;
  int             ready_pct = 100;
  logic [DW-1:0]  last_data = '0;
  logic [BW-1:0]  exp_q[$];

  typedef struct {
    int            kind;
    int            ready_pct;
    int            exp_beats;
    int            exp_cycles;
    bit            chk_last;
    logic [DW-1:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] make_image(input int kind);
    logic [N*DW-1:0] img;
    for (int k = 0; k < N; k++) begin
      case (kind)
        0:       img[k*DW +: DW] = DW'(k);
        1:       img[k*DW +: DW] = 8'h11;
        2:       img[k*DW +: DW] = 8'hFF;
        default: img[k*DW +: DW] = DW'($urandom_range(0, 255));
      endcase
    end
    return img;
  endfunction

  // Reference: every element in row-major order, then the optional modular sum.
  task automatic push_frame(input logic [N*DW-1:0] img);
    logic [DW-1:0] d;
    logic [DW-1:0] sum;
    sum = '0;
    for (int k = 0; k < N; k++) begin
      d   = img[k*DW +: DW];
      sum = sum + d;
      exp_q.push_back({(k == N - 1) && !CHK, RW'(k / P), CW'(k % P), d});
    end
    if (CHK) exp_q.push_back({1'b1, RW'(M - 1), CW'(P - 1), sum});
  endtask

  // Downstream ready, redrawn each cycle after the DUT has updated.
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.m_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: a beat seen valid&ready at negedge transfers on the following posedge.
  initial begin : monitor
    logic          stall_q;
    logic [BW-1:0] stall_beat;
    logic [BW-1:0] cur;
    stall_q = 1'b0;
    stall_beat = '0;
    forever begin
      @(negedge clk);
      cur = {bus.m_last, bus.m_row, bus.m_col, bus.m_data};
      if (rst) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_valid", 32'(bus.m_valid), 32'd1);
          check("hold_beat", 32'(cur), 32'(stall_beat));
        end
        if (bus.m_valid && bus.m_ready) begin
          frame_beats++;
          if (bus.m_last) last_data = bus.m_data;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat at %0t", cur, $time);
          end else begin
            check("beat", 32'(cur), 32'(exp_q.pop_front()));
          end
        end
        stall_q    = bus.m_valid && !bus.m_ready;
        stall_beat = cur;
      end
    end
  end

  task automatic pulse_done(input logic [N*DW-1:0] img);
    @(posedge clk);
    #1;
    result_c = img;
    done_in  = 1'b1;
    push_frame(img);
    @(negedge clk);
    check("pre_capture_valid", 32'(bus.m_valid), 32'd0);
    @(posedge clk);
    #1;
    done_in  = 1'b0;
    result_c = make_image(3);
    @(negedge clk);
    check("capture_latency", 32'(bus.m_valid), 32'd1);
  endtask

  task automatic wait_present(input logic [DW-1:0] d, input bit want_last, input string name);
    int n;
    n = 0;
    while (!(bus.m_valid && (want_last ? bus.m_last : (bus.m_data == d))) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 500), 32'd1);
  endtask

  task automatic wait_idle(input string name, output int cycles);
    cycles = 0;
    while ((busy || exp_q.size() != 0) && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    check(name, 32'(cycles < 2000), 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    logic [N*DW-1:0] img;

    vecs[0] = '{0, 100, FRAME_LEN, FRAME_LEN, 1'b1, CHK ? 8'hE0 : 8'h3F};
    vecs[1] = '{1, 100, FRAME_LEN, FRAME_LEN, 1'b1, CHK ? 8'h40 : 8'h11};
    vecs[2] = '{3,  60, FRAME_LEN, 0,         1'b0, 8'h00};
    vecs[3] = '{3,  25, FRAME_LEN, 0,         1'b0, 8'h00};
    vecs[4] = '{0,  50, FRAME_LEN, 0,         1'b1, CHK ? 8'hE0 : 8'h3F};

    rst      = 1'b1;
    done_in  = 1'b0;
    result_c = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_data", 32'(bus.m_data), 32'd0);
    check("rst_row", 32'(bus.m_row), 32'd0);
    check("rst_col", 32'(bus.m_col), 32'd0);
    check("rst_last", 32'(bus.m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      ready_pct   = vecs[i].ready_pct;
      frame_beats = 0;
      pulse_done(make_image(vecs[i].kind));
      wait_idle("frame_idle", cycles);
      if (vecs[i].exp_cycles != 0) check("frame_cycles", 32'(cycles), 32'(vecs[i].exp_cycles));
      check("frame_beats", 32'(frame_beats), 32'(vecs[i].exp_beats));
      if (vecs[i].chk_last) check("frame_last_data", 32'(last_data), 32'(vecs[i].exp_last));
      check("frame_overrun", 32'(overrun), 32'd0);
    end

    // Backpressure while element 5 is presented.
    ready_pct = 100;
    pulse_done(make_image(0));
    wait_present(8'h04, 1'b0, "bp_reach_4");
    ready_pct = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.m_valid), 32'd1);
      check("bp_data", 32'(bus.m_data), 32'h05);
      check("bp_row", 32'(bus.m_row), 32'd0);
      check("bp_col", 32'(bus.m_col), 32'd5);
      check("bp_ready_low", 32'(bus.m_ready), 32'd0);
    end
    ready_pct = 100;
    wait_idle("bp_idle", cycles);

    // Level-high done yields exactly one frame.
    frame_beats = 0;
    @(posedge clk);
    #1;
    img      = make_image(0);
    result_c = img;
    done_in  = 1'b1;
    push_frame(img);
    repeat (200) @(posedge clk);
    #1;
    done_in = 1'b0;
    wait_idle("level_idle", cycles);
    check("level_beats", 32'(frame_beats), 32'(FRAME_LEN));
    check("level_overrun", 32'(overrun), 32'd0);

    // A second rise mid-frame is dropped and flagged.
    frame_beats = 0;
    pulse_done(make_image(0));
    wait_present(8'h0A, 1'b0, "ovr_reach_10");
    result_c = make_image(2);
    done_in  = 1'b1;
    @(posedge clk);
    #1;
    done_in = 1'b0;
    @(negedge clk);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_busy", 32'(busy), 32'd1);
    wait_idle("ovr_idle", cycles);
    check("ovr_beats", 32'(frame_beats), 32'(FRAME_LEN));
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-frame aborts and clears everything, then a fresh frame starts at element 0.
    pulse_done(make_image(0));
    wait_present(8'h14, 1'b0, "rstmid_reach_20");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rstmid_valid", 32'(bus.m_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_overrun", 32'(overrun), 32'd0);
    check("rstmid_data", 32'(bus.m_data), 32'd0);
    check("rstmid_rowcol", 32'({bus.m_row, bus.m_col}), 32'd0);
    check("rstmid_last", 32'(bus.m_last), 32'd0);
    frame_beats = 0;
    pulse_done(make_image(3));
    wait_idle("rstmid_idle", cycles);
    check("rstmid_beats", 32'(frame_beats), 32'(FRAME_LEN));

    // Back-to-back: rise coincident with the final handshake of frame A.
    ready_pct = 100;
    pulse_done(make_image(0));
    wait_present(8'h00, 1'b1, "b2b_reach_last");
    img      = make_image(1);
    result_c = img;
    done_in  = 1'b1;
    push_frame(img);
    @(posedge clk);
    #1;
    done_in = 1'b0;
    @(negedge clk);
    check("b2b_valid", 32'(bus.m_valid), 32'd1);
    check("b2b_data", 32'(bus.m_data), 32'h11);
    check("b2b_rowcol", 32'({bus.m_row, bus.m_col}), 32'd0);
    check("b2b_overrun", 32'(overrun), 32'd0);
    wait_idle("b2b_idle", cycles);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
